// File: rtl/bcd_xs3_serial_conv.sv
// bcd_xs3_serial_conv
// Bit-serial BCD <-> excess-3 converter over a frame of DIGITS 4-bit digits.
// Data arrives LSB first, least-significant digit first. Each digit is converted
// independently (+3 in mode 0, -3 in mode 1) with zero-latency Mealy output.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse, begins a frame when idle (latches mode)
//   mode       0 = BCD->XS-3, 1 = XS-3->BCD
//   X          serial input bit, in_valid qualifies it
//   S          converted bit, valid when out_valid
//   out_valid  in_valid gated by RUN
//   V          one-cycle pulse after each digit: carry-out (mode 0) / borrow-out (mode 1)
//   err        one-cycle pulse after each digit: invalid code for the mode
//   done       one-cycle pulse with the last digit's V/err
//   busy       high while RUN
// Optional (macro XS3_PAR_OUT_EN):
//   q_digit    last completed converted digit, parallel
//   q_valid    one-cycle pulse with V/err
module bcd_xs3_serial_conv #(
  parameter int unsigned DIGITS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       X,
  input  logic       in_valid,
  output logic       S,
  output logic       out_valid,
  output logic       V,
  output logic       err,
  output logic       done,
  output logic       busy
`ifdef XS3_PAR_OUT_EN
  ,
  output logic [3:0] q_digit,
  output logic       q_valid
`endif
);

  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LastDig = DW'(DIGITS - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          r_state, w_state_next;
  logic [1:0]      r_bit_cnt;
  logic [DW-1:0]   r_dig_cnt;
  logic            r_cy;
  logic            r_mode;
  logic [2:0]      r_shift;  // first three bits of the digit; X completes it at bit 3
  logic            r_v, r_err, r_done;

  logic            w_accept;
  logic            w_ck;
  logic            w_cy_next;
  logic            w_last_bit;
  logic            w_frame_end;
  logic [3:0]      w_digit;
  logic            w_err_next;

  assign w_accept    = (r_state == StRun) && in_valid;
  assign w_ck        = ~r_bit_cnt[1];  // constant 0011, LSB first
  assign w_last_bit  = (r_bit_cnt == 2'd3);
  assign w_frame_end = w_accept && w_last_bit && (r_dig_cnt == LastDig);
  assign w_digit     = {X, r_shift};

  always_comb begin
    if (r_mode == 1'b0) begin
      w_cy_next  = (X & w_ck) | (X & r_cy) | (w_ck & r_cy);
      w_err_next = (w_digit > 4'd9);
    end else begin
      w_cy_next  = (~X & (w_ck | r_cy)) | (w_ck & r_cy);
      w_err_next = (w_digit < 4'd3) || (w_digit > 4'd12);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = StRun;
      StRun:  if (w_frame_end) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign S         = X ^ w_ck ^ r_cy;
  assign out_valid = w_accept;
  assign busy      = (r_state == StRun);
  assign V         = r_v;
  assign err       = r_err;
  assign done      = r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_bit_cnt <= 2'd0;
      r_dig_cnt <= '0;
      r_cy      <= 1'b0;
      r_mode    <= 1'b0;
      r_shift   <= 3'd0;
      r_v       <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_v     <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      if ((r_state == StIdle) && start) begin
        r_mode    <= mode;
        r_bit_cnt <= 2'd0;
        r_dig_cnt <= '0;
        r_cy      <= 1'b0;
      end else if (w_accept) begin
        r_bit_cnt <= r_bit_cnt + 2'd1;
        r_shift   <= w_digit[3:1];
        if (w_last_bit) begin
          // No inter-digit carry: each digit starts fresh.
          r_cy   <= 1'b0;
          r_v    <= w_cy_next;
          r_err  <= w_err_next;
          r_done <= w_frame_end;
          if (r_dig_cnt != LastDig) r_dig_cnt <= r_dig_cnt + 1'b1;
        end else begin
          r_cy <= w_cy_next;
        end
      end
    end
  end

`ifdef XS3_PAR_OUT_EN
  logic [2:0] r_s_shift;
  logic [3:0] r_q_digit;
  logic       r_q_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_shift <= 3'd0;
      r_q_digit <= 4'd0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (w_accept) begin
        r_s_shift <= {S, r_s_shift[2:1]};
        if (w_last_bit) begin
          r_q_digit <= {S, r_s_shift};
          r_q_valid <= 1'b1;
        end
      end
    end
  end

  assign q_digit = r_q_digit;
  assign q_valid = r_q_valid;
`endif

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Bench for bcd_xs3_serial_conv: three instances (DIGITS = 1, 2, 3) share the serial
// inputs, each has its own start. Expected S bits and per-digit results are queued as
// stimulus is driven and popped when the selected instance produces them; unselected
// instances must stay idle.
module tb_bcd_xs3_serial_conv;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       X = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] start_v = 3'b000;

  logic s_w [3];
  logic ov_w [3];
  logic v_w [3];
  logic err_w [3];
  logic done_w [3];
  logic busy_w [3];
`ifdef XS3_PAR_OUT_EN
  logic [3:0] qd_w [3];
  logic       qv_w [3];
`endif

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_xs3_serial_conv #(.DIGITS(g + 1)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start_v[g]),
      .mode      (mode),
      .X         (X),
      .in_valid  (in_valid),
      .S         (s_w[g]),
      .out_valid (ov_w[g]),
      .V         (v_w[g]),
      .err       (err_w[g]),
      .done      (done_w[g]),
      .busy      (busy_w[g])
`ifdef XS3_PAR_OUT_EN
      ,
      .q_digit   (qd_w[g]),
      .q_valid   (qv_w[g])
`endif
    );
  end

  typedef struct packed {
    logic       md;
    logic [3:0] d;
    logic [3:0] es;
    logic       ev;
    logic       ee;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic       e;
    logic       dn;
    logic [3:0] es;
  } res_t;

  vec_t tbl [12];
  logic s_q [$];
  res_t r_q [$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   sel = 0;
  logic m_busy = 1'b0;
  int   m_bits = 0;
  logic m_res_due = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic queue_empty(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expectation queue empty (dut %0d, t=%0t)", name, sel, $time);
  endtask

  task automatic check_cycle();
    res_t r;
    logic exp_ov;
    exp_ov = m_busy && in_valid;
    cmp("busy", 8'(busy_w[sel]), 8'(m_busy));
    cmp("out_valid", 8'(ov_w[sel]), 8'(exp_ov));
    if (exp_ov) begin
      if (s_q.size() == 0) queue_empty("S");
      else cmp("S", 8'(s_w[sel]), 8'(s_q.pop_front()));
    end
    r = '0;
    if (m_res_due) begin
      if (r_q.size() == 0) queue_empty("digit_result");
      else r = r_q.pop_front();
    end
    cmp("V", 8'(v_w[sel]), 8'(r.v));
    cmp("err", 8'(err_w[sel]), 8'(r.e));
    cmp("done", 8'(done_w[sel]), 8'(r.dn));
`ifdef XS3_PAR_OUT_EN
    cmp("q_valid", 8'(qv_w[sel]), 8'(m_res_due));
    if (m_res_due) cmp("q_digit", 8'(qd_w[sel]), 8'(r.es));
`endif
    for (int i = 0; i < 3; i++) begin
      if (i != sel)
        cmp("idle_dut", 8'({busy_w[i], ov_w[i], v_w[i], err_w[i], done_w[i]}), 8'd0);
    end
  endtask

  // One clock cycle: drive after posedge, check at negedge, advance the model.
  task automatic step(input logic st, input logic vld, input logic x, input logic rst,
                      input logic es);
    start_v      = 3'b000;
    start_v[sel] = st;
    in_valid     = vld;
    X            = x;
    reset        = rst;
    if (vld && m_busy) s_q.push_back(es);
    @(negedge clock);
    check_cycle();
    m_res_due = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_bits = 0;
      s_q.delete();
      r_q.delete();
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1;
        m_bits = 0;
      end
    end else if (vld) begin
      m_bits++;
      if (m_bits % 4 == 0) m_res_due = 1'b1;
      if (m_bits == 4 * (sel + 1)) m_busy = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input logic md);
    mode = md;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Mode input is flipped during the digit to show it is only sampled at start.
  task automatic send_digit(input logic md, input logic [3:0] d, input logic [3:0] es,
                            input logic ev, input logic ee, input logic last,
                            input int gap, input logic st_mid);
    res_t r;
    mode = ~md;
    for (int k = 0; k < 4; k++) begin
      step(st_mid && (k == 2), 1'b1, d[k], 1'b0, es[k]);
      if (k == 1)
        for (int j = 0; j < gap; j++) step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    r.v  = ev;
    r.e  = ee;
    r.dn = last;
    r.es = es;
    r_q.push_back(r);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //         md    digit  S-digit V     err
    tbl[0]  = '{1'b0, 4'd5,  4'd8,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd9,  4'd12, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd13, 4'd0,  1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'd0,  4'd3,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd12, 4'd15, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'd15, 4'd2,  1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'd3,  4'd0,  1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'd12, 4'd9,  1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd1,  4'd14, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 4'd0,  4'd13, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 4'd13, 4'd10, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'd7,  4'd4,  1'b0, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    // Reset state, with start and in_valid asserted to show reset priority.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // Single-digit frames, back to back: each start lands in the previous done cycle.
    sel = 0;
    for (int i = 0; i < 12; i++) begin
      start_frame(tbl[i].md);
      send_digit(tbl[i].md, tbl[i].d, tbl[i].es, tbl[i].ev, tbl[i].ee, 1'b1, 0, 1'b0);
    end
    idle();

    // Two digits, mode 0: 9 then 13; then in_valid bits while idle.
    sel = 1;
    start_frame(1'b0);
    send_digit(1'b0, 4'd9, 4'd12, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_digit(1'b0, 4'd13, 4'd0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Three digits, mode 1: 0011, 1100, 0001.
    sel = 2;
    start_frame(1'b1);
    send_digit(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_digit(1'b1, 4'd12, 4'd9, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_digit(1'b1, 4'd1, 4'd14, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle();

    // Stall of 3 cycles between bits 1 and 2, plus a start pulse during RUN.
    sel = 0;
    start_frame(1'b0);
    send_digit(1'b0, 4'd5, 4'd8, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    idle();

    // Reset after 6 accepted bits abandons the frame.
    sel = 2;
    start_frame(1'b0);
    send_digit(1'b0, 4'd9, 4'd12, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // digit 5, bit 0 -> S=0
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // digit 5, bit 1 -> S=0
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    sel = 0;
    start_frame(1'b0);
    send_digit(1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle();

    if (s_q.size() != 0 || r_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover: %0d S and %0d digit expectations never produced",
               s_q.size(), r_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_xs3_serial_conv.md
Name: bcd_xs3_serial_conv

Overview:
- Parametrised bit-serial converter between BCD and excess-3 (XS-3) for a multi-digit frame.
- Input is serial, LSB first, 4 bits per digit, least-significant digit first.
- Mode selects BCD->XS-3 (add 0011) or XS-3->BCD (subtract 0011).
- Adds frame control, stall-tolerant valid handshake, per-digit overflow/borrow and invalid-code flags. Sits between the serial front end and the digit display/checker logic.

Parameters:
DIGITS, 4, number of 4-bit digits per frame (>=1)

Ports:
clock      in   1  rising-edge clock
reset      in   1  synchronous, active-high; clears all state on the clock edge
start      in   1  one-cycle pulse; begins a frame when idle
mode       in   1  0 = BCD->XS-3, 1 = XS-3->BCD; sampled only on accepted start
X          in   1  serial data bit, LSB first
in_valid   in   1  X is valid this cycle
S          out  1  converted serial bit (Mealy; combinational from X and state)
out_valid  out  1  S is valid; equals in_valid while RUN, else 0
V          out  1  registered one-cycle pulse; digit produced carry-out (mode 0) or borrow-out (mode 1)
err        out  1  registered one-cycle pulse; digit code is invalid for the mode
done       out  1  registered one-cycle pulse; frame complete
busy       out  1  high while RUN

Behaviour:
- Reset values: state IDLE; bit counter 0; digit counter 0; carry/borrow 0; digit shift register 0; mode latch 0; V, err, done 0; busy 0; out_valid 0. S is don't-care while out_valid is 0.
- Two states, IDLE and RUN.
  - IDLE: start=1 latches mode, clears the counters and carry, and moves to RUN next cycle. in_valid is ignored in IDLE.
  - RUN: start is ignored.
- Bit acceptance:
  - A bit is accepted in any RUN cycle with in_valid=1.
  - When in_valid=0, nothing advances: counters, carry and shift register hold, and out_valid=0. Gaps of any length are legal.
- Per-bit arithmetic at bit position k (0..3), with constant bit c_k = 1 for k=0,1 and 0 for k=2,3:
  - Mode 0: S = X ^ c_k ^ cy; next cy = majority(X, c_k, cy).
  - Mode 1: S = X ^ c_k ^ bw; next bw = (~X & (c_k | bw)) | (c_k & bw).
  - S is valid in the same cycle X is accepted (zero latency).
- Digit boundaries:
  - Carry/borrow clears to 0 after bit 3, so each digit is converted independently. There is no inter-digit carry.
  - The 4 accepted X bits are shifted into a digit register.
  - On the cycle after bit 3 is accepted:
    - V = final carry/borrow.
    - err = (mode 0: digit > 9) or (mode 1: digit < 3 or digit > 12).
  - V and err are each high for exactly one cycle.
- Frame end:
  - After bit 3 of digit DIGITS-1 is accepted, the state returns to IDLE.
  - done pulses on the next cycle, coincident with that digit's V/err.
  - busy drops in the same cycle done is asserted.
  - A start in the done cycle is accepted (state is IDLE).
- Counters:
  - Bit counter is 2 bits and wraps 3->0.
  - Digit counter width is max(1, clog2(DIGITS)) and never wraps past DIGITS-1.
- Reset mid-frame: abandons the frame, with no done, V or err pulse. Reset has priority over start and in_valid.

Optional Feature:
- Macro: XS3_PAR_OUT_EN.
- When defined, two extra outputs are present:
  - q_digit[3:0]: registered parallel converted digit (the 4 S bits of the last completed digit).
  - q_valid: one-cycle pulse, coincident with V/err.
  - Both reset to 0. q_digit holds its value until the next digit completes.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, DIGITS=1, start then X=1,0,1,0 (digit 5) -> S=0,0,0,1 (8); next cycle V=0, err=0, done=1; busy then 0.
- Mode 0, digits 9 then 13 (DIGITS=2):
  - Digit 9 -> S=0,0,1,1 (12), V=0, err=0.
  - Digit 13 -> S=0,0,0,0, V=1, err=1, done=1.
- Mode 1, digits 0011 then 1100 then 0001 (DIGITS=3):
  - 0011 -> S=0000.
  - 1100 -> S=1001 (9).
  - 0001 -> S=0,1,1,1, V=1, err=1, done with the third digit.
- Stall: mode 0 digit 5 with in_valid low for 3 cycles between bits 1 and 2 -> out_valid low during the gap; S sequence and V/done timing are unchanged relative to accepted bits.
- Start pulsed during RUN, and in_valid bits in IDLE -> no effect on the frame; out_valid=0 in IDLE.
- Reset after 6 accepted bits -> next cycle busy=0 and no done/V/err; a new frame then converts digit 0 -> 0011 correctly. With XS3_PAR_OUT_EN, q_digit=0011 and q_valid pulses.
